// File: rtl/csr_ctrl.sv
// Machine-mode CSR file with a multi-cycle sequencer for CSR ops, ECALL entry and MRET return.
// All CSR updates go through a single write port, one register per cycle.
module csr_ctrl #(
  parameter logic [31:0] MVENDORID = 32'h7973_7978,
  parameter logic [31:0] MARCHID   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_type,
  input  logic [1:0]  i_cmd_funct,
  input  logic [11:0] i_cmd_addr,
  input  logic [31:0] i_cmd_src,
  input  logic [31:0] i_cmd_pc,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic [31:0] o_rsp_target,
  output logic        o_rsp_illegal
);

  typedef enum logic [2:0] {
    StIdle, StRead, StWrite, StTEpc, StTCause, StTStat, StRStat, StResp
  } state_t;

  localparam logic [11:0] AddrMstatus   = 12'h300;
  localparam logic [11:0] AddrMtvec     = 12'h305;
  localparam logic [11:0] AddrMepc      = 12'h341;
  localparam logic [11:0] AddrMcause    = 12'h342;
  localparam logic [11:0] AddrMvendorid = 12'hF11;
  localparam logic [11:0] AddrMarchid   = 12'hF12;

  state_t      r_state, w_state_d;
  logic [1:0]  r_type, r_funct;
  logic [11:0] r_addr;
  logic [31:0] r_src, r_pc;
  logic [31:0] r_rdata, r_target;
  logic        r_illegal;
  logic [31:0] r_mstatus, r_mtvec, r_mepc, r_mcause;

  logic        w_accept;
  logic [31:0] w_old, w_alu, w_wdata;
  logic        w_mapped, w_ro, w_illegal_op, w_we;
  logic [11:0] w_waddr;

  assign w_accept      = (r_state == StIdle) && i_cmd_valid;
  assign o_cmd_ready   = (r_state == StIdle);
  assign o_rsp_valid   = (r_state == StResp);
  assign o_rsp_rdata   = r_rdata;
  assign o_rsp_target  = r_target;
  assign o_rsp_illegal = r_illegal;

  always_comb begin
    w_old    = 32'h0;
    w_mapped = 1'b1;
    w_ro     = 1'b0;
    case (r_addr)
      AddrMstatus:   w_old = r_mstatus;
      AddrMtvec:     w_old = r_mtvec;
      AddrMepc:      w_old = r_mepc;
      AddrMcause:    w_old = r_mcause;
      AddrMvendorid: begin w_old = MVENDORID; w_ro = 1'b1; end
      AddrMarchid:   begin w_old = MARCHID;   w_ro = 1'b1; end
      default:       w_mapped = 1'b0;
    endcase
  end

  // ALU works on the value captured in READ, not the live register.
  always_comb begin
    w_alu = r_src;
    case (r_funct)
      2'b10:   w_alu = r_rdata | r_src;
      2'b11:   w_alu = r_rdata & ~r_src;
      default: w_alu = r_src;
    endcase
  end

  assign w_illegal_op = (r_funct == 2'b00) || !w_mapped ||
                        (w_ro && ((r_funct == 2'b01) || (r_src != 32'h0)));

  always_comb begin
    w_state_d = r_state;
    w_we      = 1'b0;
    w_waddr   = r_addr;
    w_wdata   = w_alu;
    case (r_state)
      StIdle: begin
        if (i_cmd_valid) begin
          case (i_cmd_type)
            2'b00:   w_state_d = StRead;
            2'b01:   w_state_d = StTEpc;
            2'b10:   w_state_d = StRStat;
            default: w_state_d = StResp;
          endcase
        end
      end
      StRead:  w_state_d = StWrite;
      StWrite: begin
        w_we      = !w_illegal_op;
        w_state_d = StResp;
      end
      StTEpc: begin
        w_we      = 1'b1;
        w_waddr   = AddrMepc;
        w_wdata   = r_pc;
        w_state_d = StTCause;
      end
      StTCause: begin
        w_we      = 1'b1;
        w_waddr   = AddrMcause;
        w_wdata   = 32'd11;
        w_state_d = StTStat;
      end
      StTStat: begin
        w_we      = 1'b1;
        w_waddr   = AddrMstatus;
        w_wdata   = {r_mstatus[31:13], 2'b11, r_mstatus[10:8], r_mstatus[3],
                     r_mstatus[6:4], 1'b0, r_mstatus[2:0]};
        w_state_d = StResp;
      end
      StRStat: begin
        w_we      = 1'b1;
        w_waddr   = AddrMstatus;
        w_wdata   = {r_mstatus[31:13], 2'b11, r_mstatus[10:8], 1'b1,
                     r_mstatus[6:4], r_mstatus[7], r_mstatus[2:0]};
        w_state_d = StResp;
      end
      StResp: if (i_rsp_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_type    <= 2'b00;
      r_funct   <= 2'b00;
      r_addr    <= 12'h0;
      r_src     <= 32'h0;
      r_pc      <= 32'h0;
      r_rdata   <= 32'h0;
      r_target  <= 32'h0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_type    <= i_cmd_type;
        r_funct   <= i_cmd_funct;
        r_addr    <= i_cmd_addr;
        r_src     <= i_cmd_src;
        r_pc      <= i_cmd_pc;
        r_rdata   <= 32'h0;
        r_target  <= 32'h0;
        r_illegal <= (i_cmd_type == 2'b11);
      end
      case (r_state)
        StRead:  r_rdata <= w_old;
        StWrite: if (w_illegal_op) begin
          r_illegal <= 1'b1;
          r_rdata   <= 32'h0;
        end
        StTStat: r_target <= r_mtvec;
        StRStat: r_target <= r_mepc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mstatus <= 32'h0000_1800;
      r_mtvec   <= 32'h0;
      r_mepc    <= 32'h0;
      r_mcause  <= 32'h0;
    end else if (w_we) begin
      case (w_waddr)
        AddrMstatus: r_mstatus <= w_wdata;
        AddrMtvec:   r_mtvec   <= {w_wdata[31:2], 2'b00};
        AddrMepc:    r_mepc    <= {w_wdata[31:2], 2'b00};
        AddrMcause:  r_mcause  <= w_wdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed bench for csr_ctrl: CSR ops, ECALL/MRET, illegal cases, backpressure, mid-trap reset.
module tb_csr_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_illegal;
  logic [1:0]  cmd_type, cmd_funct;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_src, cmd_pc, rsp_rdata, rsp_target;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  csr_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_type(cmd_type), .i_cmd_funct(cmd_funct), .i_cmd_addr(cmd_addr),
    .i_cmd_src(cmd_src), .i_cmd_pc(cmd_pc), .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_target(rsp_target),
    .o_rsp_illegal(rsp_illegal)
  );

  // Drives one command and waits (bounded) for the response; lat=99 means no response.
  task automatic issue(input logic [1:0] t, input logic [1:0] f, input logic [11:0] a,
                       input logic [31:0] s, input logic [31:0] p, output int lat);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_type = t; cmd_funct = f; cmd_addr = a; cmd_src = s; cmd_pc = p;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 99;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i + 1;
        break;
      end
    end
  endtask

  task automatic complete();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d, output logic ill);
    int lat;
    issue(2'b00, 2'b10, a, 32'h0, 32'h0, lat);
    d   = rsp_rdata;
    ill = rsp_illegal;
    complete();
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] v);
    int lat;
    issue(2'b00, 2'b01, a, v, 32'h0, lat);
    complete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    n_checks++; if (rsp_target !== 32'h0) begin n_fail++; $display("FAIL reset_target: got %h want 0", rsp_target); end
    n_checks++; if (rsp_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", rsp_illegal); end
  endtask

  task automatic test_rs_read();
    int lat; logic [31:0] d; logic ill;
    issue(2'b00, 2'b10, 12'h300, 32'h0, 32'h0, lat);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL csr_latency: got %0d want 3", lat); end
    n_checks++; if (rsp_rdata !== 32'h0000_1800) begin n_fail++; $display("FAIL rs_rdata: got %h want 00001800", rsp_rdata); end
    n_checks++; if (rsp_illegal !== 1'b0) begin n_fail++; $display("FAIL rs_illegal: got %b want 0", rsp_illegal); end
    complete();
    csr_read(12'h300, d, ill);
    n_checks++; if (d !== 32'h0000_1800) begin n_fail++; $display("FAIL mstatus_unchanged: got %h want 00001800", d); end
  endtask

  task automatic test_mtvec_mask();
    int lat; logic [31:0] d; logic ill;
    issue(2'b00, 2'b01, 12'h305, 32'h8000_0003, 32'h0, lat);
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL mtvec_old: got %h want 0", rsp_rdata); end
    complete();
    csr_read(12'h305, d, ill);
    n_checks++; if (d !== 32'h8000_0000) begin n_fail++; $display("FAIL mtvec_mask: got %h want 80000000", d); end
    // RC clears selected bits of mtvec.
    issue(2'b00, 2'b11, 12'h305, 32'h8000_0000, 32'h0, lat);
    complete();
    csr_read(12'h305, d, ill);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mtvec_rc: got %h want 0", d); end
  endtask

  task automatic test_ecall();
    int lat; logic [31:0] d; logic ill;
    csr_write(12'h300, 32'h0000_1808);
    csr_write(12'h305, 32'h8000_0200);
    issue(2'b01, 2'b00, 12'h0, 32'h0, 32'h8000_0100, lat);
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL ecall_latency: got %0d want 4", lat); end
    n_checks++; if (rsp_target !== 32'h8000_0200) begin n_fail++; $display("FAIL ecall_target: got %h want 80000200", rsp_target); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL ecall_rdata: got %h want 0", rsp_rdata); end
    complete();
    csr_read(12'h341, d, ill);
    n_checks++; if (d !== 32'h8000_0100) begin n_fail++; $display("FAIL ecall_mepc: got %h want 80000100", d); end
    csr_read(12'h342, d, ill);
    n_checks++; if (d !== 32'd11) begin n_fail++; $display("FAIL ecall_mcause: got %h want 0000000b", d); end
    csr_read(12'h300, d, ill);
    n_checks++; if (d !== 32'h0000_1880) begin n_fail++; $display("FAIL ecall_mstatus: got %h want 00001880", d); end
  endtask

  task automatic test_mret();
    int lat; logic [31:0] d; logic ill;
    issue(2'b10, 2'b00, 12'h0, 32'h0, 32'h0, lat);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL mret_latency: got %0d want 2", lat); end
    n_checks++; if (rsp_target !== 32'h8000_0100) begin n_fail++; $display("FAIL mret_target: got %h want 80000100", rsp_target); end
    complete();
    csr_read(12'h300, d, ill);
    n_checks++; if (d !== 32'h0000_1888) begin n_fail++; $display("FAIL mret_mstatus: got %h want 00001888", d); end
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] d; logic ill;
    issue(2'b00, 2'b01, 12'hF11, 32'h5, 32'h0, lat);
    n_checks++; if (rsp_illegal !== 1'b1) begin n_fail++; $display("FAIL ro_write_illegal: got %b want 1", rsp_illegal); end
    n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL ro_write_rdata: got %h want 0", rsp_rdata); end
    complete();
    csr_read(12'hF11, d, ill);
    n_checks++; if (d !== 32'h7973_7978 || ill !== 1'b0) begin n_fail++; $display("FAIL mvendorid: got %h/%b want 79737978/0", d, ill); end
    issue(2'b00, 2'b10, 12'h7C0, 32'h1, 32'h0, lat);
    n_checks++; if (rsp_illegal !== 1'b1) begin n_fail++; $display("FAIL unmapped_illegal: got %b want 1", rsp_illegal); end
    complete();
    issue(2'b00, 2'b00, 12'h300, 32'hFFFF_FFFF, 32'h0, lat);
    n_checks++; if (rsp_illegal !== 1'b1) begin n_fail++; $display("FAIL funct0_illegal: got %b want 1", rsp_illegal); end
    complete();
    csr_read(12'h300, d, ill);
    n_checks++; if (d !== 32'h0000_1888) begin n_fail++; $display("FAIL funct0_nowrite: got %h want 00001888", d); end
    issue(2'b11, 2'b01, 12'h300, 32'h0, 32'h0, lat);
    n_checks++; if (lat != 1 || rsp_illegal !== 1'b1) begin n_fail++; $display("FAIL reserved_type: got lat %0d ill %b want 1/1", lat, rsp_illegal); end
    complete();
    issue(2'b00, 2'b11, 12'hF12, 32'h0, 32'h0, lat);
    n_checks++; if (rsp_illegal !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL marchid_rc0: got %h/%b want 0/0", rsp_rdata, rsp_illegal); end
    complete();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(2'b00, 2'b10, 12'h300, 32'h0, 32'h0, lat);
    // Commands offered while busy must be ignored.
    cmd_valid = 1'b1; cmd_type = 2'b01; cmd_pc = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_rdata !== 32'h0000_1888 ||
          rsp_target !== 32'h0 || rsp_illegal !== 1'b0)
      begin
        n_fail++;
        $display("FAIL hold_%0d: got v%b r%b %h %h %b want 1 0 00001888 00000000 0",
                 i, rsp_valid, cmd_ready, rsp_rdata, rsp_target, rsp_illegal);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL handshake_cycle_ready: got %b want 0", cmd_ready); end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    n_checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL after_handshake: got r%b v%b want 1 0", cmd_ready, rsp_valid); end
  endtask

  task automatic test_reset_midtrap();
    logic [31:0] d; logic ill;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_type = 2'b01; cmd_pc = 32'h8000_0400;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(negedge clk);  // now in T_CAUSE, mepc already written
    rst = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
        rsp_target !== 32'h0 || rsp_illegal !== 1'b0)
    begin
      n_fail++;
      $display("FAIL midtrap_outputs: got r%b v%b %h %h %b want 1 0 0 0 0",
               cmd_ready, rsp_valid, rsp_rdata, rsp_target, rsp_illegal);
    end
    @(negedge clk);
    rst = 1'b0;
    csr_read(12'h341, d, ill);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midtrap_mepc: got %h want 0", d); end
    csr_read(12'h300, d, ill);
    n_checks++; if (d !== 32'h0000_1800) begin n_fail++; $display("FAIL midtrap_mstatus: got %h want 00001800", d); end
    csr_read(12'h305, d, ill);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midtrap_mtvec: got %h want 0", d); end
    csr_read(12'h342, d, ill);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midtrap_mcause: got %h want 0", d); end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_type = 2'b00; cmd_funct = 2'b00; cmd_addr = 12'h0;
    cmd_src = 32'h0; cmd_pc = 32'h0; rsp_ready = 1'b0; rst = 1'b0;
    test_reset();
    test_rs_read();
    test_mtvec_mask();
    test_ecall();
    test_mret();
    test_illegal();
    test_backpressure();
    test_reset_midtrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
